datawidthconv_32_to_512: RTL

DATAWIDTHCONV_32_TO_512 -- requirements
Module: datawidthconv_32_to_512

---
 rtl/datawidthconv_32_to_512_if.sv | 25 ++
 rtl/datawidthconv_32_to_512.sv | 106 ++++++++++
 2 files changed

// File: rtl/datawidthconv_32_to_512_if.sv
// Bus bundle for the 32-to-512 width converter: kick/status, memory read port, beat source.
// The converter itself uses the master modport; the environment drives through slave.
interface datawidthconv_32_to_512_if;
    logic         kick;
    logic         busy;
    logic         done;
    logic [31:0]  mem_raddr;
    logic         mem_re;
    logic [31:0]  mem_rdata;
    logic         src_ready;
    logic         src_valid;
    logic         src_sop;
    logic         src_eop;
    logic [511:0] src_dout;

    modport master (
        input  kick, mem_rdata, src_ready,
        output busy, done, mem_raddr, mem_re, src_valid, src_sop, src_eop, src_dout
    );

    modport slave (
        output kick, mem_rdata, src_ready,
        input  busy, done, mem_raddr, mem_re, src_valid, src_sop, src_eop, src_dout
    );
endinterface

// File: rtl/datawidthconv_32_to_512.sv
// Reads 16 consecutive 32-bit memory words per beat and presents them as one 512-bit beat,
// repeating for NUM_BEATS beats per packet started by kick.
module datawidthconv_32_to_512 #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_BEATS = 32
) (
    input logic                       clk,
    input logic                       reset,
    datawidthconv_32_to_512_if.master bus_io
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StSend  = 2'd3;

    localparam logic [15:0] LastBeat = 16'(NUM_BEATS - 1);

    logic [1:0]   state_q, state_d;
    logic [15:0]  beat_q, beat_d;
    logic [3:0]   word_q, word_d;
    logic         done_q, done_d;
    logic         rd_pend_q;
    logic [3:0]   rd_idx_q;
    logic [511:0] data_q;

    logic fetch, send, last_beat;

    assign fetch     = (state_q == StFetch);
    assign send      = (state_q == StSend);
    assign last_beat = (beat_q == LastBeat);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        word_d  = word_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_io.kick) begin
                    state_d = StFetch;
                    beat_d  = '0;
                    word_d  = '0;
                end
            end
            StFetch: begin
                // word_q wraps to 0 after the 16th read, ready for the next beat
                word_d = word_q + 4'd1;
                if (word_q == 4'd15) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StSend;
            end
            StSend: begin
                if (bus_io.src_ready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StFetch;
                        beat_d  = beat_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            done_q    <= done_d;
            // Read data arrives one cycle after the request; remember which lane it belongs to
            rd_pend_q <= fetch;
            rd_idx_q  <= word_q;
            if (rd_pend_q) begin
                data_q[{rd_idx_q, 5'b0} +: 32] <= bus_io.mem_rdata;
            end
        end
    end

    // Outputs are forced low combinationally while reset is held, whatever the state
    always_comb begin
        bus_io.busy      = (state_q != StIdle) && !reset;
        bus_io.done      = done_q && !reset;
        bus_io.mem_re    = fetch && !reset;
        bus_io.mem_raddr = bus_io.mem_re ? (BASE_ADDR + {10'b0, beat_q, word_q, 2'b00}) : '0;
        bus_io.src_valid = send && !reset;
        bus_io.src_sop   = bus_io.src_valid && (beat_q == 16'd0);
        bus_io.src_eop   = bus_io.src_valid && last_beat;
        bus_io.src_dout  = reset ? '0 : data_q;
    end

endmodule
